alu: RTL and testbench

Registered arithmetic unit of the simple microprocessor datapath. It takes two register-file operands (`Reg1_Out`, `Reg2_Out`) and one-hot operation strobes from the control unit. It performs add, subtract, multiply or pass-through and registers the result on `Alu_Out` for the memory/write-back stage. Single clock domain, one-cycle latency.

---
 rtl/alu_if.sv | 36 +++
 rtl/alu.sv | 83 ++++++++
 tb/tb_alu.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// Control-unit to ALU bundle: operation strobes, operands and registered result.
// Optional Alu_Zero/Alu_Carry signals exist only when ALU_FLAGS_EN is defined.
interface alu_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  Alu_Add;
  logic                  Alu_Sub;
  logic                  Alu_Mul;
  logic                  Alu_Pass;
  logic [DATA_WIDTH-1:0] Reg1_Out;
  logic [DATA_WIDTH-1:0] Reg2_Out;
  logic [DATA_WIDTH-1:0] Alu_Out;
  logic                  Alu_Valid;
`ifdef ALU_FLAGS_EN
  logic                  Alu_Zero;
  logic                  Alu_Carry;

  modport master (
    output Alu_Add, Alu_Sub, Alu_Mul, Alu_Pass, Reg1_Out, Reg2_Out,
    input  Alu_Out, Alu_Valid, Alu_Zero, Alu_Carry
  );
  modport slave (
    input  Alu_Add, Alu_Sub, Alu_Mul, Alu_Pass, Reg1_Out, Reg2_Out,
    output Alu_Out, Alu_Valid, Alu_Zero, Alu_Carry
  );
`else
  modport master (
    output Alu_Add, Alu_Sub, Alu_Mul, Alu_Pass, Reg1_Out, Reg2_Out,
    input  Alu_Out, Alu_Valid
  );
  modport slave (
    input  Alu_Add, Alu_Sub, Alu_Mul, Alu_Pass, Reg1_Out, Reg2_Out,
    output Alu_Out, Alu_Valid
  );
`endif
endinterface

// File: rtl/alu.sv
// Registered add/sub/mul/pass unit with one-cycle latency and priority Add > Sub > Mul > Pass.
// Define ALU_FLAGS_EN to build the Alu_Zero/Alu_Carry flag registers and carry logic.
module alu #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic Clk,
  input  logic Reset,
  alu_if.slave bus
);

  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_op_valid;
  logic [DATA_WIDTH-1:0] r_out;
  logic                  r_valid;

`ifdef ALU_FLAGS_EN
  logic                    w_carry;
  logic [2*DATA_WIDTH-1:0] w_prod;
  logic                    r_zero;
  logic                    r_carry;
`endif

  assign w_op_valid = bus.Alu_Add | bus.Alu_Sub | bus.Alu_Mul | bus.Alu_Pass;

  always_comb begin
    w_result = '0;
`ifdef ALU_FLAGS_EN
    w_carry  = 1'b0;
    w_prod   = '0;
    if (bus.Alu_Add) begin
      {w_carry, w_result} = {1'b0, bus.Reg1_Out} + {1'b0, bus.Reg2_Out};
    end else if (bus.Alu_Sub) begin
      w_result = bus.Reg1_Out - bus.Reg2_Out;
      w_carry  = (bus.Reg1_Out < bus.Reg2_Out);
    end else if (bus.Alu_Mul) begin
      w_prod   = {{DATA_WIDTH{1'b0}}, bus.Reg1_Out} * {{DATA_WIDTH{1'b0}}, bus.Reg2_Out};
      w_result = w_prod[DATA_WIDTH-1:0];
      w_carry  = |w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
    end else if (bus.Alu_Pass) begin
      w_result = bus.Reg2_Out;
    end
`else
    if (bus.Alu_Add) begin
      w_result = bus.Reg1_Out + bus.Reg2_Out;
    end else if (bus.Alu_Sub) begin
      w_result = bus.Reg1_Out - bus.Reg2_Out;
    end else if (bus.Alu_Mul) begin
      w_result = bus.Reg1_Out * bus.Reg2_Out;
    end else if (bus.Alu_Pass) begin
      w_result = bus.Reg2_Out;
    end
`endif
  end

  // Result and flags only load on a sampled strobe; idle cycles hold them.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_out   <= '0;
      r_valid <= 1'b0;
`ifdef ALU_FLAGS_EN
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
`endif
    end else begin
      r_valid <= w_op_valid;
      if (w_op_valid) begin
        r_out   <= w_result;
`ifdef ALU_FLAGS_EN
        r_zero  <= (w_result == '0);
        r_carry <= w_carry;
`endif
      end
    end
  end

  assign bus.Alu_Out   = r_out;
  assign bus.Alu_Valid = r_valid;
`ifdef ALU_FLAGS_EN
  assign bus.Alu_Zero  = r_zero;
  assign bus.Alu_Carry = r_carry;
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: each step pushes its expected result, pops it one edge later.
module tb_alu;
  localparam int unsigned W = 16;

  typedef struct packed {
    logic [W-1:0] out;
    logic         valid;
    logic         zero;
    logic         carry;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset;
  alu_if #(.DATA_WIDTH(W)) bus ();
  alu #(.DATA_WIDTH(W)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always #5 Clk = ~Clk;

  exp_t q[$];
  exp_t last;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Drive at negedge, push expectation, wait past the sampling edge.
  task automatic step(input logic add, input logic sub, input logic mul, input logic pass,
                      input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    @(negedge Clk);
    bus.Alu_Add  = add;
    bus.Alu_Sub  = sub;
    bus.Alu_Mul  = mul;
    bus.Alu_Pass = pass;
    bus.Reg1_Out = a;
    bus.Reg2_Out = b;
    q.push_back(e);
    last = e;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    exp_t e;
    #1;
    n_checks++;
    if (bus.Alu_Out !== '0 || bus.Alu_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: out=%h valid=%b required out=0 valid=0", bus.Alu_Out, bus.Alu_Valid);
    end
    @(negedge Clk);
    Reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 16'h1234, '{16'h1234, 1'b1, 1'b0, 1'b0});
    e = q.pop_front();
    n_checks++;
    if (bus.Alu_Out !== e.out || bus.Alu_Valid !== e.valid) begin
      n_fail++;
      $display("FAIL reset_preload: out=%h valid=%b required out=%h valid=%b", bus.Alu_Out, bus.Alu_Valid, e.out, e.valid);
    end
    // Mid-cycle async assertion, well before the next edge.
    #1 Reset = 1'b1;
    #1;
    n_checks++;
    if (bus.Alu_Out !== '0 || bus.Alu_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: out=%h valid=%b required out=0 valid=0", bus.Alu_Out, bus.Alu_Valid);
    end
`ifdef ALU_FLAGS_EN
    n_checks++;
    if (bus.Alu_Zero !== 1'b0 || bus.Alu_Carry !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: zero=%b carry=%b required 0 0", bus.Alu_Zero, bus.Alu_Carry);
    end
`endif
    // Strobe during reset must be discarded.
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'd7, 16'd8, '{16'd0, 1'b0, 1'b0, 1'b0});
    e = q.pop_front();
    n_checks++;
    if (bus.Alu_Out !== e.out || bus.Alu_Valid !== e.valid) begin
      n_fail++;
      $display("FAIL reset_discard: out=%h valid=%b required out=%h valid=%b", bus.Alu_Out, bus.Alu_Valid, e.out, e.valid);
    end
    @(negedge Clk);
    Reset = 1'b0;
    bus.Alu_Add = 1'b0;
  endtask

  task automatic test_vectors(input string name, input logic [3:0] strb,
                              input logic [W-1:0] a, input logic [W-1:0] b, input exp_t ev);
    exp_t e;
    step(strb[3], strb[2], strb[1], strb[0], a, b, ev);
    e = q.pop_front();
    n_checks++;
    if (bus.Alu_Out !== e.out || bus.Alu_Valid !== e.valid) begin
      n_fail++;
      $display("FAIL %s: out=%0d valid=%b required out=%0d valid=%b", name, bus.Alu_Out, bus.Alu_Valid, e.out, e.valid);
    end
`ifdef ALU_FLAGS_EN
    n_checks++;
    if (bus.Alu_Zero !== e.zero || bus.Alu_Carry !== e.carry) begin
      n_fail++;
      $display("FAIL %s_flags: zero=%b carry=%b required zero=%b carry=%b", name, bus.Alu_Zero, bus.Alu_Carry, e.zero, e.carry);
    end
`endif
  endtask

  task automatic test_arith;
    test_vectors("add",    4'b1000, 16'd30000, 16'd40000, '{16'd4464,  1'b1, 1'b0, 1'b1});
    test_vectors("sub_wr", 4'b0100, 16'd5,     16'd7,     '{16'd65534, 1'b1, 1'b0, 1'b1});
    test_vectors("sub_z",  4'b0100, 16'd7,     16'd7,     '{16'd0,     1'b1, 1'b1, 1'b0});
    test_vectors("mul_hi", 4'b0010, 16'd300,   16'd300,   '{16'd24464, 1'b1, 1'b0, 1'b1});
    test_vectors("mul_lo", 4'b0010, 16'd12,    16'd11,    '{16'd132,   1'b1, 1'b0, 1'b0});
  endtask

  task automatic test_pass_idle;
    test_vectors("pass",  4'b0001, 16'd99, 16'd1234, '{16'd1234, 1'b1, 1'b0, 1'b0});
    test_vectors("idle",  4'b0000, 16'd55, 16'd66,   '{16'd1234, 1'b0, 1'b0, 1'b0});
    test_vectors("idle2", 4'b0000, 16'd0,  16'd0,    '{16'd1234, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic test_priority;
    test_vectors("pri_addsub",  4'b1100, 16'd10, 16'd3, '{16'd13, 1'b1, 1'b0, 1'b0});
    test_vectors("pri_mulpass", 4'b0011, 16'd4,  16'd5, '{16'd20, 1'b1, 1'b0, 1'b0});
    test_vectors("pri_all",     4'b1111, 16'hFFFF, 16'd1, '{16'd0, 1'b1, 1'b1, 1'b1});
  endtask

  task automatic test_back_to_back;
    exp_t e;
    logic [3:0] strb;
    logic [W-1:0] a, b;
    longint unsigned full;
    for (int i = 0; i < 24; i++) begin
      strb = 4'b0001 << $urandom_range(0, 3);
      a = W'($urandom);
      b = W'($urandom);
      if (i % 4 == 0) a = b;
      case (strb)
        4'b1000: begin full = longint'(a) + longint'(b);
                       e = '{full[W-1:0], 1'b1, full[W-1:0] == 0, full[W]}; end
        4'b0100: begin full = longint'(a) - longint'(b);
                       e = '{full[W-1:0], 1'b1, full[W-1:0] == 0, a < b}; end
        4'b0010: begin full = longint'(a) * longint'(b);
                       e = '{full[W-1:0], 1'b1, full[W-1:0] == 0, full[2*W-1:W] != 0}; end
        default:       e = '{b, 1'b1, b == 0, 1'b0};
      endcase
      test_vectors("b2b", strb, a, b, e);
    end
  endtask

  initial begin
    Reset = 1'b1;
    bus.Alu_Add = 1'b0;
    bus.Alu_Sub = 1'b0;
    bus.Alu_Mul = 1'b0;
    bus.Alu_Pass = 1'b0;
    bus.Reg1_Out = '0;
    bus.Reg2_Out = '0;
    test_reset();
    test_arith();
    test_pass_idle();
    test_priority();
    test_back_to_back();
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
